// File: rtl/demultiplexor_tdm1to4_pkg.sv
// Shared types and constants for the 4-slot TDM receive demultiplexor.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {WAIT_SYNC, RECV} tdm_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/demultiplexor_tdm1to4_if.sv
// Serial-in / per-slot-out bus of the TDM demultiplexor.
// parity_err exists only when TDM_PARITY_EN is defined.
interface demultiplexor_tdm1to4_if #(
  parameter int WIDTH = 8
);
  import tdm_pkg::*;

  logic                             bit_in;
  logic                             bit_valid;
  logic                             frame_sync;
  logic [NUM_SLOTS-1:0][WIDTH-1:0]  out_data;
  logic [NUM_SLOTS-1:0]             out_valid;
  logic                             frame_done;
  logic                             busy;
`ifdef TDM_PARITY_EN
  logic                             parity_err;

  modport master (
    output bit_in, bit_valid, frame_sync,
    input  out_data, out_valid, frame_done, busy, parity_err
  );

  modport slave (
    input  bit_in, bit_valid, frame_sync,
    output out_data, out_valid, frame_done, busy, parity_err
  );
`else
  modport master (
    output bit_in, bit_valid, frame_sync,
    input  out_data, out_valid, frame_done, busy
  );

  modport slave (
    input  bit_in, bit_valid, frame_sync,
    output out_data, out_valid, frame_done, busy
  );
`endif

endinterface

// File: rtl/demultiplexor_tdm1to4_slot_shifter.sv
// LSB-first deserializer for one slot; word_o is the word including the current beat.
module slot_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_first_i,
  input  logic             shift_i,
  input  logic             bit_in_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] word_q, word_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    word_d = word_q;
    if (load_first_i) begin
      word_d = {bit_in_i, {(WIDTH-1){1'b0}}};
    end else if (shift_i) begin
      word_d = {bit_in_i, word_q[WIDTH-1:1]};
    end
  end

  // Bits enter at the MSB and move down, so after WIDTH beats bit 0 sits at the LSB.
  assign word_o = word_d;

  // NOTE: sequential state uses non-blocking assignments only; blocking ones race between blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/demultiplexor_tdm1to4.sv
// 4-slot TDM receiver: serial stream in, one holding register plus strobe per slot.
// Optional per-slot even-parity bit enabled by TDM_PARITY_EN.
module demultiplexor_tdm1to4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  demultiplexor_tdm1to4_if.slave bus
);

`ifdef TDM_PARITY_EN
  localparam int SLOT_LEN = WIDTH + 1;
`else
  localparam int SLOT_LEN = WIDTH;
`endif
  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  tdm_state_t                      state_q, state_d;
  logic [SLOT_W-1:0]               slot_q, slot_d;
  logic [CNT_W-1:0]                bitcnt_q, bitcnt_d;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] data_q, data_d;
  logic [NUM_SLOTS-1:0]            valid_q, valid_d;
  logic                            done_q, done_d;
`ifdef TDM_PARITY_EN
  logic                            perr_q, perr_d;
`endif
  logic                            load_first;
  logic                            shift;
  logic [WIDTH-1:0]                word;

  slot_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .load_first_i (load_first),
    .shift_i      (shift),
    .bit_in_i     (bus.bit_in),
    .word_o       (word)
  );

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    bitcnt_d   = bitcnt_q;
    data_d     = data_q;
    valid_d    = '0;
    done_d     = 1'b0;
`ifdef TDM_PARITY_EN
    perr_d     = 1'b0;
`endif
    load_first = 1'b0;
    shift      = 1'b0;

    if (bus.bit_valid) begin
      if (bus.frame_sync) begin
        // A sync always restarts the frame, discarding any partial slot.
        load_first = 1'b1;
        state_d    = RECV;
        slot_d     = '0;
        bitcnt_d   = CNT_W'(1);
      end else if (state_q == RECV) begin
`ifdef TDM_PARITY_EN
        shift = (bitcnt_q < CNT_W'(WIDTH));
`else
        shift = 1'b1;
`endif
        if (bitcnt_q == LAST_BIT) begin
          bitcnt_d = '0;
          slot_d   = slot_q + SLOT_W'(1);
`ifdef TDM_PARITY_EN
          // The parity beat is not shifted in, so word already holds the full data.
          if (even_parity(32'(word)) != bus.bit_in) begin
            perr_d = 1'b1;
          end else begin
            data_d[slot_q]  = word;
            valid_d[slot_q] = 1'b1;
          end
`else
          data_d[slot_q]  = word;
          valid_d[slot_q] = 1'b1;
`endif
          if (slot_q == LAST_SLOT) begin
            done_d  = 1'b1;
            state_d = WAIT_SYNC;
          end
        end else begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the holding registers are ordinary flops with a defined reset value, so they
  // are reset along with the control state rather than left to power-up contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_SYNC;
      slot_q   <= '0;
      bitcnt_q <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      done_q   <= 1'b0;
`ifdef TDM_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef TDM_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = (state_q == RECV);
`ifdef TDM_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule
